// File: rtl/link_status_2_pkg.sv
// Link Status 2 field positions, access masks and a packed view of the register.
package link_status_2_pkg;

    localparam int LS2_W = 16;

    localparam int LS2_CUR_DEEMPH_BIT   = 0;
    localparam int LS2_EQ_8GT_CPL_BIT   = 1;
    localparam int LS2_EQ_PH1_BIT       = 2;
    localparam int LS2_EQ_PH2_BIT       = 3;
    localparam int LS2_EQ_PH3_BIT       = 4;
    localparam int LS2_EQ_REQ_8GT_BIT   = 5;
    localparam int LS2_RETIMER_BIT      = 6;
    localparam int LS2_TWO_RETIMERS_BIT = 7;
    localparam int LS2_XLINK_LO_BIT     = 8;
    localparam int LS2_XLINK_HI_BIT     = 9;
    localparam int LS2_FLIT_MODE_BIT    = 10;
    localparam int LS2_RSVDZ_BIT        = 11;
    localparam int LS2_DS_PRES_LO_BIT   = 12;
    localparam int LS2_DS_PRES_HI_BIT   = 14;
    localparam int LS2_DRS_RCVD_BIT     = 15;

    localparam logic [LS2_W-1:0] LS2_RW1C_MASK  = 16'h8020;
    localparam logic [LS2_W-1:0] LS2_RO_MASK    = 16'h77DF;
    localparam logic [LS2_W-1:0] LS2_RSVDZ_MASK = 16'h0800;

    typedef struct packed {
        logic       drs_msg_rcvd;
        logic [2:0] ds_comp_pres;
        logic       rsvdz;
        logic       flit_mode;
        logic [1:0] crosslink_res;
        logic       two_retimers;
        logic       retimer_pres;
        logic       eq_req_8gt;
        logic [2:0] eq_phase_ok;
        logic       eq_8gt_cpl;
        logic       cur_deemph;
    } link_status_2_t;

endpackage

// File: rtl/link_status_2_sync.sv
// SYNC_STAGES-deep 16-bit flop chain for level status; wires straight through at depth 0.
module link_status_2_sync
    import link_status_2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LS2_W-1:0] d_i,
    output logic [LS2_W-1:0] q_o
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0][LS2_W-1:0] chain_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= d_i;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        chain_q[s] <= chain_q[s-1];
                    end
                end
            end

            assign q_o = chain_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/link_status_2_regfile.sv
// Per-link PCIe Link Status 2 registers: synchronised RO fields, RW1C event bits,
// single-outstanding valid/ready config access and a maskable per-link event irq.
module link_status_2_regfile
    import link_status_2_pkg::*;
#(
    parameter  int NUM_LINKS   = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_LINKS-1:0][LS2_W-1:0]   hw_status,
    input  logic [NUM_LINKS-1:0]              hw_eq_req_set,
    input  logic [NUM_LINKS-1:0]              hw_drs_set,
    input  logic [NUM_LINKS-1:0]              irq_mask,
    input  logic                              cfg_req_valid,
    output logic                              cfg_req_ready,
    input  logic                              cfg_req_write,
    input  logic [IDX_W-1:0]                  cfg_req_link,
    input  logic [LS2_W-1:0]                  cfg_req_wdata,
    output logic                              cfg_rsp_valid,
    input  logic                              cfg_rsp_ready,
    output logic [LS2_W-1:0]                  cfg_rsp_rdata,
    output logic                              cfg_rsp_err,
    output logic [NUM_LINKS-1:0][LS2_W-1:0]   status_q,
    output logic [NUM_LINKS-1:0]              irq
);

    logic [NUM_LINKS-1:0][LS2_W-1:0] sync_status;
    logic [NUM_LINKS-1:0][LS2_W-1:0] status_d;
    logic [NUM_LINKS-1:0]            irq_q;
    logic                            rsp_valid_q, rsp_err_q;
    logic [LS2_W-1:0]                rsp_rdata_q;
    logic                            accept, in_range, wr_hit;

    generate
        for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
            link_status_2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (hw_status[i]),
                .q_o   (sync_status[i])
            );

            link_status_2_t cur;
            assign cur = link_status_2_t'(status_q[i]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) irq_q[i] <= 1'b0;
                else        irq_q[i] <= (cur.eq_req_8gt | cur.drs_msg_rcvd) & ~irq_mask[i];
            end
        end
    endgenerate

    assign cfg_req_ready = !rsp_valid_q || cfg_rsp_ready;
    assign accept        = cfg_req_valid && cfg_req_ready;
    assign in_range      = int'(cfg_req_link) < NUM_LINKS;
    assign wr_hit        = accept && cfg_req_write && in_range;

    // Set is OR-ed after the clear so a same-cycle hardware event wins.
    always_comb begin
        status_d = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            logic [LS2_W-1:0] set_v, clr_v;
            set_v = '0;
            set_v[LS2_EQ_REQ_8GT_BIT] = hw_eq_req_set[i];
            set_v[LS2_DRS_RCVD_BIT]   = hw_drs_set[i];
            clr_v = (wr_hit && int'(cfg_req_link) == i) ? (cfg_req_wdata & LS2_RW1C_MASK) : '0;
            status_d[i] = (sync_status[i] & LS2_RO_MASK)
                        | (((status_q[i] & ~clr_v) | set_v) & LS2_RW1C_MASK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= '0;
        else        status_q <= status_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !in_range;
            rsp_rdata_q <= (!cfg_req_write && in_range) ? status_q[cfg_req_link] : '0;
        end else if (cfg_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign cfg_rsp_valid = rsp_valid_q;
    assign cfg_rsp_err   = rsp_err_q;
    assign cfg_rsp_rdata = rsp_rdata_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_link_status_2_regfile.sv
// Directed bench for link_status_2_regfile with 5 links (index 5..7 out of range).
module tb_link_status_2_regfile;
    localparam int NL = 5;
    localparam int IW = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NL-1:0][15:0]     hw_status;
    logic [NL-1:0]           hw_eq_req_set, hw_drs_set, irq_mask;
    logic                    cfg_req_valid, cfg_req_ready, cfg_req_write;
    logic [IW-1:0]           cfg_req_link;
    logic [15:0]             cfg_req_wdata;
    logic                    cfg_rsp_valid, cfg_rsp_ready, cfg_rsp_err;
    logic [15:0]             cfg_rsp_rdata;
    logic [NL-1:0][15:0]     status_q;
    logic [NL-1:0]           irq;

    int nvec = 0;
    int nerr = 0;

    link_status_2_regfile #(.NUM_LINKS(NL), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .hw_status(hw_status),
        .hw_eq_req_set(hw_eq_req_set), .hw_drs_set(hw_drs_set), .irq_mask(irq_mask),
        .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
        .cfg_req_write(cfg_req_write), .cfg_req_link(cfg_req_link),
        .cfg_req_wdata(cfg_req_wdata), .cfg_rsp_valid(cfg_rsp_valid),
        .cfg_rsp_ready(cfg_rsp_ready), .cfg_rsp_rdata(cfg_rsp_rdata),
        .cfg_rsp_err(cfg_rsp_err), .status_q(status_q), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [IW-1:0] lnk, input logic [15:0] wd);
        cfg_req_valid = 1'b1;
        cfg_req_write = wr;
        cfg_req_link  = lnk;
        cfg_req_wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        hw_status = '0; hw_eq_req_set = '0; hw_drs_set = '0; irq_mask = '0;
        cfg_req_valid = 1'b0; cfg_req_write = 1'b0; cfg_req_link = '0;
        cfg_req_wdata = '0; cfg_rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_status", 32'(status_q), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rsp_valid", 32'(cfg_rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(cfg_req_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // read link 0 after reset
        req(1'b0, 3'd0, 16'h0);
        tick();
        cfg_req_valid = 1'b0;
        chk("rd0_valid", 32'(cfg_rsp_valid), 32'h1);
        chk("rd0_rdata", 32'(cfg_rsp_rdata), 32'h0);
        chk("rd0_err", 32'(cfg_rsp_err), 32'h0);
        tick();
        chk("rd0_consumed", 32'(cfg_rsp_valid), 32'h0);

        // RO sampling through two sync flops plus the field register
        hw_status[2] = 16'hFFFF;
        tick(); tick();
        chk("ro_lat2", 32'(status_q[2]), 32'h0);
        tick();
        chk("ro_lat3", 32'(status_q[2]), 32'h77DF);
        tick();
        chk("ro_hold", 32'(status_q[2]), 32'h77DF);
        chk("ro_irq", 32'(irq), 32'h0);

        // DRS pulse on link 1, then RW1C write-0 / write-1
        hw_drs_set[1] = 1'b1;
        tick();
        hw_drs_set[1] = 1'b0;
        chk("drs_set", 32'(status_q[1]), 32'h8000);
        chk("drs_irq_n1", 32'(irq), 32'h0);
        tick();
        chk("drs_irq", 32'(irq), 32'h02);
        req(1'b1, 3'd1, 16'h0020);
        tick();
        chk("w0020_keep", 32'(status_q[1]), 32'h8000);
        chk("w_rsp_valid", 32'(cfg_rsp_valid), 32'h1);
        chk("w_rsp_rdata", 32'(cfg_rsp_rdata), 32'h0);
        req(1'b1, 3'd1, 16'h8000);
        tick();
        cfg_req_valid = 1'b0;
        chk("w8000_clr", 32'(status_q[1]), 32'h0);
        chk("w8000_irq_n1", 32'(irq), 32'h02);
        tick();
        chk("w8000_irq_n2", 32'(irq), 32'h0);

        // set wins over same-cycle clear on link 3
        hw_eq_req_set[3] = 1'b1;
        req(1'b1, 3'd3, 16'h0020);
        tick();
        hw_eq_req_set[3] = 1'b0;
        cfg_req_valid = 1'b0;
        chk("set_wins", 32'(status_q[3]), 32'h0020);
        tick();
        chk("eq_irq", 32'(irq), 32'h08);
        irq_mask[3] = 1'b1;
        tick();
        chk("mask_irq", 32'(irq), 32'h0);
        irq_mask[3] = 1'b0;
        req(1'b1, 3'd3, 16'hFFFF);
        tick();
        cfg_req_valid = 1'b0;
        chk("eq_clr", 32'(status_q[3]), 32'h0);

        // response backpressure: read link 2 then stall 5 cycles
        tick();
        cfg_rsp_ready = 1'b0;
        req(1'b0, 3'd2, 16'h0);
        tick();
        req(1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(cfg_rsp_valid), 32'h1);
            chk("stall_rdata", 32'(cfg_rsp_rdata), 32'h77DF);
            chk("stall_ready", 32'(cfg_req_ready), 32'h0);
            tick();
        end
        cfg_rsp_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(cfg_req_ready), 32'h1);
        tick();
        cfg_req_valid = 1'b0;
        chk("second_valid", 32'(cfg_rsp_valid), 32'h1);
        chk("second_rdata", 32'(cfg_rsp_rdata), 32'h0);
        tick();
        chk("second_done", 32'(cfg_rsp_valid), 32'h0);

        // out-of-range index: error response, writes discarded
        hw_drs_set = '1;
        tick();
        hw_drs_set = '0;
        req(1'b0, 3'd5, 16'h0);
        tick();
        chk("oor_rd_err", 32'(cfg_rsp_err), 32'h1);
        chk("oor_rd_rdata", 32'(cfg_rsp_rdata), 32'h0);
        req(1'b1, 3'd6, 16'hFFFF);
        tick();
        cfg_req_valid = 1'b0;
        chk("oor_wr_err", 32'(cfg_rsp_err), 32'h1);
        tick();
        for (int l = 0; l < NL; l++)
            chk("oor_no_write", 32'(status_q[l]), (l == 2) ? 32'hF7DF : 32'h8000);
        chk("oor_irq", 32'(irq), 32'h1F);
        req(1'b0, 3'd4, 16'h0);
        tick();
        cfg_req_valid = 1'b0;
        chk("inrange_err", 32'(cfg_rsp_err), 32'h0);
        chk("inrange_rdata", 32'(cfg_rsp_rdata), 32'h8000);

        // reset while a response is pending
        cfg_rsp_ready = 1'b0;
        req(1'b0, 3'd1, 16'h0);
        tick();
        cfg_req_valid = 1'b0;
        chk("pend_valid", 32'(cfg_rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cfg_rsp_valid), 32'h0);
        chk("mid_rst_status", 32'(status_q[1]), 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_valid", 32'(cfg_rsp_valid), 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/link_status_2_regfile.md
# link_status_2_regfile

Multi-link PCIe Link Status 2 register file that holds one architectural 16-bit Link Status 2 register per link. RO fields are sampled from synchronised hardware status. RW1C event bits are set by hardware pulses and cleared by software write-1. The block sits between the per-link PHY/LTSSM status sources and the configuration-space access path, and serves reads/writes through a valid/ready request/response handshake. It also raises a maskable per-link event interrupt.

## Interface
- NUM_LINKS, 4, number of links/registers (1..32)
- SYNC_STAGES, 2, synchroniser depth on RO status inputs (0 = no synchroniser)
- IDX_W, $clog2(NUM_LINKS) clamped to min 1, link index width (derived, not overridden)

- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- hw_status  in  NUM_LINKS x 16  level status per link; only RO bit positions used
- hw_eq_req_set  in  NUM_LINKS  1-cycle pulse, sets Link Equalization Request 8GT
- hw_drs_set  in  NUM_LINKS  1-cycle pulse, sets DRS Message Received
- irq_mask  in  NUM_LINKS  1 = suppress irq for that link
- cfg_req_valid  in  1  request valid
- cfg_req_ready  out  1  request accepted when valid & ready
- cfg_req_write  in  1  1 = write, 0 = read
- cfg_req_link  in  IDX_W  target link
- cfg_req_wdata  in  16  write data
- cfg_rsp_valid  out  1  response valid, held until consumed
- cfg_rsp_ready  in  1  response consumed when valid & ready
- cfg_rsp_rdata  out  16  read data (0 for writes/errors)
- cfg_rsp_err  out  1  link index >= NUM_LINKS
- status_q  out  NUM_LINKS x 16  current architectural register values
- irq  out  NUM_LINKS  level event interrupt per link

## Operation
- Field layout:
  - [0] current de-emphasis level, RO
  - [1] EQ 8GT complete, RO
  - [4:2] EQ phase 1/2/3 successful, RO
  - [5] link EQ request 8GT, RW1C
  - [6] retimer present, RO
  - [7] two retimers present, RO
  - [9:8] crosslink resolution, RO
  - [10] flit mode, RO
  - [11] RsvdZ
  - [14:12] downstream component presence, RO
  - [15] DRS message received, RW1C
- RO fields: hw_status passes through SYNC_STAGES flops, then into the field register. Software writes to RO bits are ignored. Bit 11 always reads 0.
- RW1C bits: set by the hardware pulse; cleared when an accepted write targets that link with a 1 in that bit position. Writing 0 has no effect. If a set and a clear hit the same bit in the same cycle, set wins.
- Request acceptance: cfg_req_ready = !cfg_rsp_valid | cfg_rsp_ready. At most one response is outstanding, and back-to-back accepts are allowed.
- Read response: rdata is status_q[link] as it stood in the accept cycle, i.e. before any same-cycle hardware update.
- Out-of-range link index: err=1, rdata=0, any write is discarded.
- irq[i]: registered; irq[i] = (status_q[i][5] | status_q[i][15]) & ~irq_mask[i].
- Reset values: all status_q bits 0, synchroniser flops 0, irq 0, cfg_rsp_valid 0, rdata 0, err 0. cfg_req_ready is 1 out of reset.

## Timing
- hw_status change visible in status_q after SYNC_STAGES+1 rising edges.
- Set pulse in cycle N: bit reads 1 in status_q from cycle N+1, irq asserts in N+2 if unmasked.
- Request accepted in cycle N: cfg_rsp_valid=1 from N+1 and held stable until cfg_rsp_ready.
- Write accepted in cycle N: bit clears in status_q from N+1, irq drops in N+2.
- irq_mask change takes effect on irq one cycle later.
- Reset mid-transaction: any pending response is dropped; no response appears after reset release.

## Structure
- Package link_status_2_pkg holds:
  - bit-position localparams for every field
  - LS2_RW1C_MASK = 16'h8020
  - LS2_RO_MASK = 16'h77DF
  - LS2_RSVDZ_MASK = 16'h0800
  - packed struct link_status_2_t mirroring the layout
- Sub-module link_status_2_sync: parametrised SYNC_STAGES x 16-bit flop chain with async active-low reset, pass-through when SYNC_STAGES=0. Instantiated once per link through a generate loop.
- The top level holds the register array, handshake logic and irq flops.

## Test plan
- Reset, then read link 0: rsp rdata=16'h0000, err=0, one cycle after accept; irq all 0.
- hw_status[2]=16'hFFFF held, SYNC_STAGES=2: status_q[2]=16'h77DF exactly 3 edges later; bits 5/11/15 stay 0.
- hw_drs_set[1] pulse: status_q[1][15]=1 next cycle, irq[1]=1 the cycle after. Write link 1 with wdata=16'h0020 leaves bit 15 set; wdata=16'h8000 clears it, and irq[1] drops 2 cycles after accept.
- Same-cycle hw_eq_req_set[3] and a write of 16'h0020 to link 3 accepted in that cycle: bit 5 remains 1.
- cfg_rsp_ready held low for 5 cycles after a read: rsp_valid/rdata stay stable, cfg_req_ready=0, and a second valid request is not accepted until the response is consumed.
- NUM_LINKS=4, read link 5 (IDX_W=2 wraps; use NUM_LINKS=3, link 3): err=1, rdata=0, a write to the same index changes no register.
